// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-pointer receiver: Gray/binary conversion and the
// multi-bit-change detector used by the optional error check.
package gray_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int GRAY_MAX_W      = 32;

    // Callers zero-extend narrower values; the leading zeros do not change the decode.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic popcount_gt1(input logic [GRAY_MAX_W-1:0] v);
        return (v & (v - GRAY_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_sync_ff.sv
// Plain WIDTH-wide, STAGES-deep synchronizer chain with asynchronous active-low reset.
module gray_sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/gray_sync_rx.sv
// Receive side of a Gray-coded pointer crossing: synchronize, decode, report progress.
// Define GRAY_SYNC_RX_ERR_CHK_EN to build the sticky illegal-transition detector.
module gray_sync_rx
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             enable,
    input  logic             err_clr,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta,
    output logic             update,
    output logic             err
);

    logic [WIDTH-1:0] gray_s;
    logic [WIDTH-1:0] bin_s;

    logic [WIDTH-1:0] gray_out_q, gray_out_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             update_q, update_d;

    gray_sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (gray_in),
        .q_out (gray_s)
    );

    assign bin_s = WIDTH'(gray2bin(GRAY_MAX_W'(gray_s)));

    // While disabled the outputs freeze, so the next capture reports all accumulated progress.
    always_comb begin
        gray_out_d = gray_out_q;
        bin_d      = bin_q;
        delta_d    = delta_q;
        update_d   = 1'b0;
        if (enable) begin
            gray_out_d = gray_s;
            bin_d      = bin_s;
            delta_d    = bin_s - bin_q;
            update_d   = (bin_s != bin_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_out_q <= '0;
            bin_q      <= '0;
            delta_q    <= '0;
            update_q   <= 1'b0;
        end else begin
            gray_out_q <= gray_out_d;
            bin_q      <= bin_d;
            delta_q    <= delta_d;
            update_q   <= update_d;
        end
    end

    assign gray_out = gray_out_q;
    assign bin_out  = bin_q;
    assign delta    = delta_q;
    assign update   = update_q;

`ifdef GRAY_SYNC_RX_ERR_CHK_EN
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIDTH-1:0]  gray_s_dly_q, gray_s_dly_d;
    logic              err_q, err_d;
    logic              fill_done;
    logic              multi_bit;

    // Right after reset the chain still carries zeros, so comparisons are meaningless until it fills.
    assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));
    assign multi_bit = popcount_gt1(GRAY_MAX_W'(gray_s ^ gray_s_dly_q));

    always_comb begin
        fill_d       = fill_done ? fill_q : fill_q + FILL_W'(1);
        gray_s_dly_d = gray_s;
        err_d        = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (fill_done && multi_bit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            gray_s_dly_q <= '0;
            err_q        <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            gray_s_dly_q <= gray_s_dly_d;
            err_q        <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_rx.sv
// Self-checking bench for gray_sync_rx (WIDTH=4, SYNC_STAGES=2): vector table with an
// expected-value queue, plus hand-written reset sequences.
module tb_gray_sync_rx;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int EXP_W       = 3 * WIDTH + 2;

`ifdef GRAY_SYNC_RX_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] gray_in;
    logic             enable;
    logic             err_clr;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] delta;
    logic             update;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] gi;
        logic             en;
        logic             clr;
        logic [WIDTH-1:0] bin;
        logic             upd;
        logic [WIDTH-1:0] dlt;
        logic             err;
    } vec_t;

    vec_t             vecs[$];
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_err    = 0;

    gray_sync_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (gray_in),
        .enable   (enable),
        .err_clr  (err_clr),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .delta    (delta),
        .update   (update),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [WIDTH-1:0] gi, input logic en, input logic clr,
                           input logic [WIDTH-1:0] b, input logic u,
                           input logic [WIDTH-1:0] d, input logic e);
        vec_t v;
        v.gi = gi; v.en = en; v.clr = clr;
        v.bin = b; v.upd = u; v.dlt = d; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [EXP_W-1:0] e;
        gray_in = v.gi;
        enable  = v.en;
        err_clr = v.clr;
        exp_q.push_back({to_gray(v.bin), v.bin, v.dlt, v.upd, (ERR_EN ? v.err : 1'b0)});
        tick();
        e = exp_q.pop_front();
        check($sformatf("v%0d.gray_out", idx), 32'(gray_out), 32'(e[EXP_W-1 -: WIDTH]));
        check($sformatf("v%0d.bin_out", idx),  32'(bin_out),  32'(e[2*WIDTH+1 -: WIDTH]));
        check($sformatf("v%0d.delta", idx),    32'(delta),    32'(e[WIDTH+1 -: WIDTH]));
        check($sformatf("v%0d.update", idx),   32'(update),   32'(e[1]));
        check($sformatf("v%0d.err", idx),      32'(err),      32'(e[0]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gray_out"}, 32'(gray_out), 32'(0));
        check({tag, ".bin_out"},  32'(bin_out),  32'(0));
        check({tag, ".delta"},    32'(delta),    32'(0));
        check({tag, ".update"},   32'(update),   32'(0));
        check({tag, ".err"},      32'(err),      32'(0));
    endtask

    initial begin
        // Count-up through every code, wrapping 15 -> 0; outputs trail inputs by two rows.
        for (int n = 0; n < 20; n++) begin
            logic [WIDTH-1:0] gi;
            gi = (n <= 15) ? to_gray(WIDTH'(n)) : '0;
            if (n < 3 || n == 19) add_vec(gi, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            else                  add_vec(gi, 1'b1, 1'b0, WIDTH'(n - 2), 1'b1, 4'd1, 1'b0);
        end
        // Disabled window of four steps, then one capture with the accumulated delta.
        add_vec(4'b0001, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0010, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0110, 1'b1, 1'b0, 4'd4, 1'b1, 4'd4, 1'b0);
        add_vec(4'b0110, 1'b1, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        // Illegal jumps with outputs frozen: set, clear, then clear colliding with a new set.
        add_vec(4'b0010, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b1);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b1);
        add_vec(4'b0011, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0011, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b1);
        add_vec(4'b0000, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 1'b1);

        // Reset held with a nonzero input: everything reads zero, err quiet during fill.
        rst_n   = 1'b0;
        gray_in = 4'b1011;
        enable  = 1'b1;
        err_clr = 1'b0;
        tick();
        tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick();
        check("fill1.err", 32'(err), 32'(0));
        tick();
        check("fill2.err", 32'(err), 32'(0));

        // Clean restart from an all-zero input before the vector table.
        rst_n   = 1'b0;
        gray_in = '0;
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Asynchronous reset mid-run clears outputs before any clock edge.
        gray_in = 4'b0010;
        enable  = 1'b1;
        err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rel1.bin_out", 32'(bin_out), 32'(0));
        check("rel1.update",  32'(update),  32'(0));
        tick();
        check("rel2.bin_out", 32'(bin_out), 32'(0));
        check("rel2.update",  32'(update),  32'(0));
        tick();
        check("rel3.gray_out", 32'(gray_out), 32'(4'b0010));
        check("rel3.bin_out",  32'(bin_out),  32'(3));
        check("rel3.update",   32'(update),   32'(1));
        check("rel3.delta",    32'(delta),    32'(3));
        check("rel3.err",      32'(err),      32'(0));
        tick();
        check("rel4.update", 32'(update), 32'(0));
        check("rel4.delta",  32'(delta),  32'(0));

        check("exp_q.drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_sync_rx.md
Name: gray_sync_rx

Overview:
- Receive end of a Gray-coded pointer/counter crossing into the clk domain.
- The remote domain holds a Gray counter (bin+1, converted to Gray, registered). This block does three things:
  - synchronizes that multi-bit Gray value through a flop chain;
  - decodes it back to binary;
  - reports per-update progress (delta) and an update strobe.
- Used as the read-side pointer receiver for async FIFOs and event counters.

Parameters:
- WIDTH, 4, bit width of the Gray value, binary value and delta.
- SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).

Ports:
- clk      input   1      receive-domain clock
- rst_n    input   1      reset, asynchronous, active-low
- gray_in  input   WIDTH  Gray value from the remote domain; asynchronous to clk; one bit changes per remote step
- enable   input   1      capture enable for decoded outputs
- err_clr  input   1      clears sticky err (only meaningful with the optional feature)
- gray_out output  WIDTH  last captured synchronized Gray value
- bin_out  output  WIDTH  binary decode of gray_out
- delta    output  WIDTH  (new bin_out - previous bin_out) mod 2^WIDTH at the last capture
- update   output  1      one-cycle pulse: bin_out changed this cycle
- err      output  1      sticky: illegal multi-bit Gray transition seen

Behaviour:
- Reset (async assert, sync release): sync chain, gray_out, bin_out, delta, update, err, fill counter all 0.
- Sync chain: gray_in -> SYNC_STAGES flops -> gray_s. Runs every cycle regardless of enable.
- Decode is combinational on gray_s: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- Capture on a clk edge with enable=1:
  - gray_out <= gray_s, bin_out <= decode(gray_s).
  - delta <= decode(gray_s) - bin_out, truncated to WIDTH.
  - update <= (decode(gray_s) != bin_out).
- With enable=0: gray_out, bin_out and delta hold; update = 0.
  - On re-enable, one capture yields the accumulated delta (mod 2^WIDTH) and a single update pulse.
- No change while enabled: update = 0, delta = 0.
- Latency: a gray_in change before edge k appears on bin_out/update after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges total.
- Wrap-around: bin 2^WIDTH-1 -> 0 gives update = 1, delta = 1. delta never signals wrap separately.
- Delta ambiguity: more than 2^WIDTH-1 remote steps during a disabled window aliases. This is not detected; callers must bound the window.
- Fill counter: counts 0..SYNC_STAGES after reset release, then saturates. While it is below SYNC_STAGES the chain is filling, and error checking is suppressed.
- Reset mid-operation: everything clears immediately. After release the first capture of a nonzero gray_s produces update = 1 and delta = the decoded value (old value = 0).

Optional Feature:
- Macro: GRAY_SYNC_RX_ERR_CHK_EN.
- Defined:
  - Keep gray_s_d, a one-cycle-delayed copy of gray_s, updated every cycle independent of enable.
  - If the fill is done and popcount(gray_s ^ gray_s_d) > 1, err <= 1 on the next edge.
  - err is sticky. err_clr=1 clears it unless an error is detected in the same cycle (set wins).
- Not defined: err is tied 0, err_clr is ignored, and no comparator, delay register or fill counter is synthesized.

Decomposition:
- Package gray_pkg:
  - functions gray2bin(WIDTH) and bin2gray;
  - function popcount_gt1;
  - localparam SYNC_STAGES_MIN = 2.
- Sub-module gray_sync_ff: WIDTH-wide, SYNC_STAGES-deep flop chain with async active-low reset, no other logic; instanced once.

Test Plan (WIDTH=4, SYNC_STAGES=2):
- Reset asserted with gray_in=1011 -> all outputs 0 during reset; err stays 0 during the fill after release.
- enable=1; gray_in 0000,0001,0011,0010 one per clock -> bin_out 1,2,3 on successive cycles starting 3 edges after the first change; update=1 and delta=1 each cycle.
- Wrap: gray_in 1001 (14) -> 1000 (15) -> 0000 (0) -> bin_out 14, 15, 0; delta=1 on each step including 15 -> 0.
- enable=0 while gray_in steps 0000 -> 0001 -> 0011 -> 0010 -> 0110 -> bin_out holds 0 and update=0; after re-enable one pulse with bin_out=4, delta=4.
- With the macro, after fill, gray_in jumps 0000 -> 0011 -> err=1 three edges later. err_clr pulse -> err=0. err_clr coincident with a new 0011 -> 0000 jump -> err stays 1. Without the macro -> err=0 throughout.
- Reset pulse mid-run with gray_in held at 0010 -> outputs clear immediately; 3 edges after release bin_out=3, update=1, delta=3, err=0.
